// File: rtl/uart_link_pkg.sv
// Packet-type constants shared with the on-chip UART/TCP mux, and the command frame-length rule.
package uart_link_pkg;

    localparam logic [7:0] PT_PARROT          = 8'd0;
    localparam logic [7:0] PT_ETH_FRAME_IN    = 8'd1;
    localparam logic [7:0] PT_ETH_FRAME_OUT   = 8'd2;
    localparam logic [7:0] PT_REMAINING_LAYER = 8'd3;
    localparam logic [7:0] PT_INSTRUCTION     = 8'd4;
    localparam logic [7:0] PT_BRAIN_STATUS    = 8'd5;
    localparam logic [7:0] PT_PAYLOAD_COMING  = 8'd6;
    localparam logic [7:0] PT_INFO            = 8'd7;

    // Total bytes on the wire for a host command, header included.
    function automatic logic [1:0] frame_len(input logic [7:0] pkt_type);
        case (pkt_type)
            PT_ETH_FRAME_IN, PT_INSTRUCTION, PT_PAYLOAD_COMING: frame_len = 2'd2;
            PT_INFO:                                            frame_len = 2'd3;
            default:                                            frame_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Byte stream with valid/ready handshake; master drives tdata/tvalid, slave drives tready.
interface axi_stream_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_link_deframer.sv
// Parses [header, data] response frames and routes data to one of four streams; output valid 1 cycle after data byte.
// Holds off link_rx while a byte awaits delivery; abandons a frame whose data byte does not arrive within RX_TIMEOUT cycles.
module uart_link_deframer
    import uart_link_pkg::*;
#(
    parameter int RX_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    axi_stream_if.slave  link_rx,
    axi_stream_if.master echo_axis,
    axi_stream_if.master frame_out_axis,
    axi_stream_if.master rest_axis,
    axi_stream_if.master status_axis,
    output logic [15:0]  bad_hdr_count,
    output logic [15:0]  timeout_count
);

    localparam int CW = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [1:0] {R_HDR, R_DATA, R_DELIVER} rx_state_e;

    rx_state_e      state, state_next;
    logic [7:0]     hdr_q, dat_q;
    logic [CW-1:0]  wait_cnt;
    logic           rx_hs, routable, expired, deliver, out_hs;

    assign rx_hs    = link_rx.tvalid && link_rx.tready;
    assign routable = (hdr_q == PT_PARROT) || (hdr_q == PT_ETH_FRAME_OUT) ||
                      (hdr_q == PT_REMAINING_LAYER) || (hdr_q == PT_BRAIN_STATUS);
    // wait_cnt holds the idle cycles already spent, so this is the RX_TIMEOUT-th one.
    assign expired  = (wait_cnt == CW'(RX_TIMEOUT - 1));
    assign deliver  = (state == R_DELIVER);

    assign echo_axis.tvalid      = deliver && (hdr_q == PT_PARROT);
    assign frame_out_axis.tvalid = deliver && (hdr_q == PT_ETH_FRAME_OUT);
    assign rest_axis.tvalid      = deliver && (hdr_q == PT_REMAINING_LAYER);
    assign status_axis.tvalid    = deliver && (hdr_q == PT_BRAIN_STATUS);
    assign echo_axis.tdata       = dat_q;
    assign frame_out_axis.tdata  = dat_q;
    assign rest_axis.tdata       = dat_q;
    assign status_axis.tdata     = dat_q;

    assign out_hs = (echo_axis.tvalid      && echo_axis.tready)      ||
                    (frame_out_axis.tvalid && frame_out_axis.tready) ||
                    (rest_axis.tvalid      && rest_axis.tready)      ||
                    (status_axis.tvalid    && status_axis.tready);

    always_comb begin
        state_next     = state;
        link_rx.tready = 1'b0;
        case (state)
            R_HDR: begin
                link_rx.tready = 1'b1;
                if (link_rx.tvalid) state_next = R_DATA;
            end
            R_DATA: begin
                link_rx.tready = 1'b1;
                if (link_rx.tvalid)  state_next = routable ? R_DELIVER : R_HDR;
                else if (expired)    state_next = R_HDR;
            end
            R_DELIVER: if (out_hs) state_next = R_HDR;
            default:   state_next = R_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= R_HDR;
            hdr_q         <= '0;
            dat_q         <= '0;
            wait_cnt      <= '0;
            bad_hdr_count <= '0;
            timeout_count <= '0;
        end else begin
            state <= state_next;
            if (state == R_HDR && rx_hs) begin
                hdr_q    <= link_rx.tdata;
                wait_cnt <= '0;
            end else if (state == R_DATA) begin
                if (rx_hs) begin
                    dat_q <= link_rx.tdata;
                    if (!routable && bad_hdr_count != 16'hFFFF)
                        bad_hdr_count <= bad_hdr_count + 16'd1;
                end else if (expired) begin
                    if (timeout_count != 16'hFFFF)
                        timeout_count <= timeout_count + 16'd1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_host_link.sv
// Frames host commands into 1-3 byte UART packets (header valid 1 cycle after accept) and deframes chip responses.
// cmd_ready is low until the whole frame has left on link_tx; each byte waits for link_tx.tready.
module uart_host_link
    import uart_link_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RX_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_type,
    input  logic [DATA_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    axi_stream_if.master          link_tx,
    axi_stream_if.slave           link_rx,
    axi_stream_if.master          echo_axis,
    axi_stream_if.master          frame_out_axis,
    axi_stream_if.master          rest_axis,
    axi_stream_if.master          status_axis,
    output logic [15:0]           bad_hdr_count,
    output logic [15:0]           timeout_count
);

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_ADDR, T_DATA} tx_state_e;

    tx_state_e             tx_state, tx_next;
    logic [DATA_WIDTH-1:0] type_q, addr_q, data_q;

    assign cmd_ready = (tx_state == T_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            type_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            tx_state <= tx_next;
            if (cmd_valid && cmd_ready) begin
                type_q <= cmd_type;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
            end
        end
    end

    always_comb begin
        tx_next        = tx_state;
        link_tx.tvalid = 1'b0;
        link_tx.tdata  = '0;
        case (tx_state)
            T_IDLE: if (cmd_valid) tx_next = T_HDR;
            T_HDR: begin
                link_tx.tvalid = 1'b1;
                link_tx.tdata  = type_q;
                if (link_tx.tready) begin
                    case (frame_len(type_q))
                        2'd2:    tx_next = T_DATA;
                        2'd3:    tx_next = T_ADDR;
                        default: tx_next = T_IDLE;
                    endcase
                end
            end
            T_ADDR: begin
                link_tx.tvalid = 1'b1;
                link_tx.tdata  = addr_q;
                if (link_tx.tready) tx_next = T_DATA;
            end
            T_DATA: begin
                link_tx.tvalid = 1'b1;
                link_tx.tdata  = data_q;
                if (link_tx.tready) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    uart_link_deframer #(
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_deframer (
        .clk            (clk),
        .rst            (rst),
        .link_rx        (link_rx),
        .echo_axis      (echo_axis),
        .frame_out_axis (frame_out_axis),
        .rest_axis      (rest_axis),
        .status_axis    (status_axis),
        .bad_hdr_count  (bad_hdr_count),
        .timeout_count  (timeout_count)
    );

endmodule

// File: tb/tb_uart_host_link.sv
// Directed bench for uart_host_link: a queue-based model of the byte protocol is checked every cycle,
// and each scenario also pins a few hand-computed values.
module tb_uart_host_link;

    localparam int RXT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_type = '0, cmd_addr = '0, cmd_data = '0;
    logic        cmd_ready;
    logic [15:0] bad_hdr_count, timeout_count;
    logic        tx_rdy = 1'b1, tx_force = 1'b1, tx_toggle = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_dat = '0;
    logic [3:0]  out_rdy = 4'hF;

    always #5 clk = ~clk;

    axi_stream_if #(.W(8)) tx_if ();
    axi_stream_if #(.W(8)) rx_if ();
    axi_stream_if #(.W(8)) echo_if ();
    axi_stream_if #(.W(8)) frame_if ();
    axi_stream_if #(.W(8)) rest_if ();
    axi_stream_if #(.W(8)) status_if ();

    assign tx_if.tready     = tx_rdy;
    assign rx_if.tvalid     = rx_vld;
    assign rx_if.tdata      = rx_dat;
    assign echo_if.tready   = out_rdy[0];
    assign frame_if.tready  = out_rdy[1];
    assign rest_if.tready   = out_rdy[2];
    assign status_if.tready = out_rdy[3];

    wire  [3:0] o_vld = {status_if.tvalid, rest_if.tvalid, frame_if.tvalid, echo_if.tvalid};
    logic [7:0] o_dat [4];
    assign o_dat[0] = echo_if.tdata;
    assign o_dat[1] = frame_if.tdata;
    assign o_dat[2] = rest_if.tdata;
    assign o_dat[3] = status_if.tdata;

    uart_host_link #(.DATA_WIDTH(8), .RX_TIMEOUT(RXT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_type       (cmd_type),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .link_tx        (tx_if),
        .link_rx        (rx_if),
        .echo_axis      (echo_if),
        .frame_out_axis (frame_if),
        .rest_axis      (rest_if),
        .status_axis    (status_if),
        .bad_hdr_count  (bad_hdr_count),
        .timeout_count  (timeout_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] tx_q[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         exp_s[$];
    logic [7:0] exp_d[$];
    int         out_s_log[$];
    logic [7:0] out_d_log[$];
    bit         m_have_hdr = 1'b0;
    logic [7:0] m_hdr = '0;
    int         m_wait = 0;
    logic [15:0] m_bad = '0, m_tmo = '0;
    int         cyc = 0;

    function automatic int route(input logic [7:0] h);
        case (h)
            8'd0:    return 0;
            8'd2:    return 1;
            8'd3:    return 2;
            8'd5:    return 3;
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        cyc++;
        if (rst) begin
            tx_q.delete();
            exp_s.delete();
            exp_d.delete();
            m_have_hdr = 1'b0;
            m_wait = 0;
            m_bad = '0;
            m_tmo = '0;
        end else begin
            // A command is outstanding exactly while bytes remain to be sent.
            chk("cmd_ready", cmd_ready, tx_q.size() == 0);
            if (tx_q.size() == 0) begin
                chk("tx_idle_vld", tx_if.tvalid, 1'b0);
            end else begin
                chk("tx_vld", tx_if.tvalid, 1'b1);
                chk("tx_dat", tx_if.tdata, tx_q[0]);
                if (tx_if.tvalid && tx_if.tready) begin
                    tx_log.push_back(tx_if.tdata);
                    tx_cyc.push_back(cyc);
                    void'(tx_q.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) begin
                tx_q.push_back(cmd_type);
                if (cmd_type == 8'd7) tx_q.push_back(cmd_addr);
                if (cmd_type inside {8'd1, 8'd4, 8'd6, 8'd7}) tx_q.push_back(cmd_data);
            end

            chk("rx_ready", rx_if.tready, exp_d.size() == 0);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out%0d_vld", i), o_vld[i], exp_d.size() != 0 && exp_s[0] == i);
                if (exp_d.size() != 0 && exp_s[0] == i) chk($sformatf("out%0d_dat", i), o_dat[i], exp_d[0]);
            end
            chk("bad_hdr_count", bad_hdr_count, m_bad);
            chk("timeout_count", timeout_count, m_tmo);
            if (exp_d.size() != 0 && o_vld[exp_s[0]] && out_rdy[exp_s[0]]) begin
                out_s_log.push_back(exp_s.pop_front());
                out_d_log.push_back(exp_d.pop_front());
            end
            if (rx_if.tvalid && rx_if.tready) begin
                if (!m_have_hdr) begin
                    m_hdr = rx_if.tdata;
                    m_have_hdr = 1'b1;
                    m_wait = 0;
                end else begin
                    m_have_hdr = 1'b0;
                    if (route(m_hdr) >= 0) begin
                        exp_s.push_back(route(m_hdr));
                        exp_d.push_back(rx_if.tdata);
                    end else if (m_bad != 16'hFFFF) begin
                        m_bad = m_bad + 16'd1;
                    end
                end
            end else if (m_have_hdr) begin
                m_wait++;
                if (m_wait == RXT) begin
                    m_have_hdr = 1'b0;
                    if (m_tmo != 16'hFFFF) m_tmo = m_tmo + 16'd1;
                end
            end
        end
    end

    // Sole driver of link_tx.tready: either a fixed level or a per-cycle toggle.
    initial forever begin
        @(posedge clk);
        #2;
        tx_rdy = tx_toggle ? !tx_rdy : tx_force;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [7:0] t, input logic [7:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        cmd_type = t;
        cmd_addr = a;
        cmd_data = d;
        cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("cmd_accept_wait", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bit ok = 1'b0;
        rx_dat = b;
        rx_vld = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rx_if.tready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("rx_accept_wait", rx_if.tready, 1'b1);
        @(posedge clk); #1;
        rx_vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (tx_q.size() == 0 && cmd_ready && exp_d.size() == 0 && !m_have_hdr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_wait", cmd_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        int base, lc;
        logic [7:0] types [7];
        types = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'hFF};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_tx_vld", tx_if.tvalid, 1'b0);
        chk("rst_out_vld", o_vld, 4'h0);
        chk("rst_rx_ready", rx_if.tready, 1'b1);
        chk("rst_bad", bad_hdr_count, 16'h0);
        chk("rst_tmo", timeout_count, 16'h0);
        @(posedge clk); #1;

        // INFO: three bytes on consecutive cycles, cmd_ready low for 3 cycles.
        base = tx_log.size();
        send_cmd(8'h07, 8'h0C, 8'hC0);
        lc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
            lc++;
        end
        chk("info_busy_cycles", lc, 3);
        chk("info_len", tx_log.size() - base, 3);
        chk("info_b0", tx_log[base], 8'h07);
        chk("info_b1", tx_log[base+1], 8'h0C);
        chk("info_b2", tx_log[base+2], 8'hC0);
        chk("info_span", tx_cyc[base+2] - tx_cyc[base], 2);
        @(posedge clk); #1;

        // INSTRUCTION under a toggling tready, then an unknown type.
        base = tx_log.size();
        tx_toggle = 1'b1;
        send_cmd(8'h04, 8'h00, 8'h5A);
        wait_idle();
        send_cmd(8'h09, 8'h33, 8'h44);
        wait_idle();
        tx_toggle = 1'b0;
        chk("toggle_len", tx_log.size() - base, 3);
        chk("instr_b0", tx_log[base], 8'h04);
        chk("instr_b1", tx_log[base+1], 8'h5A);
        chk("unknown_b0", tx_log[base+2], 8'h09);

        // Remaining types back to back; the model checks every byte.
        foreach (types[i]) send_cmd(types[i], 8'hA0 + 8'(i), 8'h50 + 8'(i));
        wait_idle();

        // ETH_FRAME_OUT response with the consumer stalled for 5 cycles.
        out_rdy[1] = 1'b0;
        rx_byte(8'h02);
        rx_byte(8'hAB);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_vld", frame_if.tvalid, 1'b1);
            chk("stall_dat", frame_if.tdata, 8'hAB);
            chk("stall_rx_ready", rx_if.tready, 1'b0);
            chk("stall_others", o_vld & 4'b1101, 4'h0);
        end
        @(posedge clk); #1;
        out_rdy[1] = 1'b1;
        base = out_s_log.size();
        wait_idle();
        chk("stall_out_n", out_s_log.size() - base, 1);
        chk("stall_out_d", out_d_log[base], 8'hAB);

        // Unroutable header, then a BRAIN_STATUS frame.
        rx_byte(8'h01);
        rx_byte(8'h33);
        repeat (3) @(negedge clk);
        chk("bad_count", bad_hdr_count, 16'd1);
        chk("bad_no_out", o_vld, 4'h0);
        @(posedge clk); #1;
        base = out_s_log.size();
        rx_byte(8'h05);
        rx_byte(8'h11);
        wait_idle();
        chk("status_s", out_s_log[base], 3);
        chk("status_d", out_d_log[base], 8'h11);

        // Header only: abort fires on the 16th idle cycle.
        rx_byte(8'h03);
        repeat (15) @(negedge clk);
        @(negedge clk);
        chk("tmo_before", timeout_count, 16'd0);
        @(negedge clk);
        chk("tmo_after", timeout_count, 16'd1);
        @(posedge clk); #1;
        base = out_s_log.size();
        rx_byte(8'h00);
        rx_byte(8'h00);
        wait_idle();
        chk("echo_s", out_s_log[base], 0);
        chk("echo_d", out_d_log[base], 8'h00);

        // Data arriving on the very cycle the timeout would fire is kept.
        base = out_s_log.size();
        rx_byte(8'h05);
        repeat (15) begin @(posedge clk); #1; end
        rx_byte(8'h77);
        wait_idle();
        chk("edge_tmo", timeout_count, 16'd1);
        chk("edge_s", out_s_log[base], 3);
        chk("edge_d", out_d_log[base], 8'h77);

        // A few routable frames through the model.
        rx_byte(8'h03); rx_byte(8'h30);
        rx_byte(8'h07); rx_byte(8'h70);
        rx_byte(8'h02); rx_byte(8'h20);
        wait_idle();
        chk("mix_bad", bad_hdr_count, 16'd2);

        // Reset after the INFO addr byte: data byte never leaves.
        base = tx_log.size();
        send_cmd(8'h07, 8'h0C, 8'hC0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        tx_force = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tx_force = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx_vld", tx_if.tvalid, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_bad", bad_hdr_count, 16'h0);
        chk("mid_rst_tmo", timeout_count, 16'h0);
        repeat (3) @(negedge clk);
        chk("mid_rst_bytes", tx_log.size() - base, 2);
        chk("mid_rst_addr", tx_log[base+1], 8'h0C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_host_link.md
# uart_host_link

Host-side counterpart of the on-chip UART/TCP multiplexer. Frames typed commands from host logic (test harness, soft-core, or FPGA host emulator) into the byte protocol the chip expects: one header byte, then zero to two argument bytes. It also parses the two-byte `[header, data]` frames the chip returns and routes each data byte to a per-type output stream. It sits directly between host logic and the byte-level UART serializer.

## Interface
Parameters
- `DATA_WIDTH`, 8: byte width of every stream; only 8 is supported.
- `RX_TIMEOUT`, 1024: maximum cycles from accepting a response header to receiving its data byte; must be at least 2.

Ports (streams are `axi_stream_if` modports carrying `tdata`/`tvalid`/`tready`)
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_type` in 8: packet type (header byte).
- `cmd_addr` in 8: INFO field index.
- `cmd_data` in 8: argument byte.
- `link_tx` master 8: bytes toward the chip's UART input.
- `link_rx` slave 8: bytes from the chip's UART output.
- `echo_axis` master 8: PARROT response data.
- `frame_out_axis` master 8: ETH_FRAME_OUT data.
- `rest_axis` master 8: REMAINING_LAYER data.
- `status_axis` master 8: BRAIN_STATUS data.
- `bad_hdr_count` out 16: count of response frames with an unroutable header; saturating.
- `timeout_count` out 16: count of abandoned response frames; saturating.

## Operation
Packet types: PARROT=0, ETH_FRAME_IN=1, ETH_FRAME_OUT=2, REMAINING_LAYER=3, INSTRUCTION=4, BRAIN_STATUS=5, PAYLOAD_COMING=6, INFO=7.

TX framer, FSM `T_IDLE → T_HDR → [T_ADDR] → [T_DATA] → T_IDLE`
- `cmd_ready` = (state == T_IDLE).
- On accept, latch type, addr and data into registers; go to T_HDR.
- Frame length depends on type:
  - 1, 4, 6: header then data (T_HDR→T_DATA).
  - 7: header, then addr, then data (T_HDR→T_ADDR→T_DATA).
  - 0 and all other values: header only (T_HDR→T_IDLE).
- `link_tx.tvalid` is high in T_HDR, T_ADDR and T_DATA; `tdata` is the latched byte for that state.
- The state advances only on a `link_tx` handshake.

RX deframer, FSM `R_HDR → R_DATA → R_DELIVER → R_HDR`
- `link_rx.tready` is high in R_HDR and R_DATA.
- In R_HDR, a handshake latches the header and clears the timeout counter.
- In R_DATA, a handshake latches the data byte:
  - Header 0, 2, 3 or 5: go to R_DELIVER.
  - Any other header: drop the byte, increment `bad_hdr_count`, return to R_HDR.
- In R_DATA, if `RX_TIMEOUT` cycles elapse without a handshake: increment `timeout_count`, return to R_HDR.
- In R_DELIVER, only the stream selected by the header asserts `tvalid` with the latched data. On its handshake, return to R_HDR.
- During R_DELIVER no further `link_rx` bytes are accepted (backpressure).

TX and RX paths are fully independent and may be active in the same cycle.

## Timing
- Reset: all FSMs to idle; every output `tvalid` = 0; `cmd_ready` = 1 from the first cycle after reset; both counters = 0; any partial frame is discarded with no counter increment.
- Command accepted at cycle N: header is valid at N+1. With `link_tx.tready` held high:
  - 2-byte frame: `cmd_ready` returns at N+3.
  - INFO: `cmd_ready` returns at N+4.
  - Header-only: `cmd_ready` returns at N+2.
- No combinational path from `cmd_*` to `link_tx`, or from `link_rx` to any output stream.
- RX: data handshake at cycle M gives output `tvalid` at M+1. The next header can be accepted at the cycle after the output handshake.
- Timeout: the counter starts the cycle after the header handshake. The abort fires on the cycle the count reaches `RX_TIMEOUT`. A data handshake in that same cycle wins (no abort).
- Counters saturate at 0xFFFF.
- `tvalid`/`tdata` are held stable until handshake; `tvalid` never drops without a handshake except on reset.

## Structure
- Package `uart_link_pkg`: the eight packet-type constants (the on-chip mux imports the same package) and a `frame_len(type)` function.
- FSM enums stay local.
- Sub-module `uart_link_deframer`: the RX FSM, timeout counter and `bad_hdr_count`. The framer stays in the top.

## Test plan
- INFO command with addr=0x0C, data=0xC0 and `link_tx.tready`=1 → `link_tx` emits 0x07, 0x0C, 0xC0 on consecutive cycles; `cmd_ready` low for 3 cycles.
- INSTRUCTION command with data=0x5A, `tready` toggling every cycle → exactly 0x04, 0x5A emitted with stable `tdata` while stalled; type 0x09 command → single byte 0x09.
- `link_rx` sends 0x02, 0xAB with `frame_out_axis.tready`=0 for 5 cycles → `tvalid` held with 0xAB, `link_rx.tready`=0 during the stall, other streams silent.
- `link_rx` sends 0x01, 0x33 → no output asserted, `bad_hdr_count`=1; the following frame 0x05, 0x11 appears on `status_axis`.
- `link_rx` sends header 0x03 only, with `RX_TIMEOUT`=16 → `timeout_count`=1 after 16 cycles; the next 0x00, 0x00 frame appears on `echo_axis`.
- Assert `rst` mid-INFO frame (after the addr byte) → `link_tx.tvalid`=0 next cycle, `cmd_ready`=1, counters 0, no stray byte emitted.
